// File: rtl/status_symbol_selector.sv
// status_symbol_selector
//   Drives the symbol-select inputs of the 5-column LED matrix scanner.
//   Two raw status lines are synchronised, debounced and priority-resolved
//   ("A" beats "G"). The shown symbol only changes on a frame boundary, and
//   only once the current symbol has been on screen for MIN_HOLD frames, so a
//   letter never tears mid-scan.
// Ports:
//   CLK        in  system clock (shared with the scanner)
//   RST        in  asynchronous active-high reset
//   RAW_A      in  raw "A" request, asynchronous, may bounce
//   RAW_G      in  raw "G" request, asynchronous, may bounce
//   FRAME_SYNC in  one-cycle pulse at the start of each scan frame
//   AS         out registered select for "A"
//   GT         out registered select for "G" (never high together with AS)
//   CHANGED    out one-cycle pulse on the edge where the shown symbol changes
module status_symbol_selector #(
  parameter int DEB_CYCLES = 16,
  parameter int MIN_HOLD   = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic RAW_A,
  input  logic RAW_G,
  input  logic FRAME_SYNC,
  output logic AS,
  output logic GT,
  output logic CHANGED
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(MIN_HOLD + 1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // The flip happens on the edge where the count would reach DEB_CYCLES,
  // i.e. when it currently sits at DEB_CYCLES-1.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  localparam logic [HW-1:0] HOLD_ONE = HW'(1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);

  typedef enum logic [1:0] {
    SHOW_0 = 2'b00,
    SHOW_A = 2'b01,
    SHOW_G = 2'b10
  } state_t;

  // Index 0 carries the A line, index 1 the G line.
  logic [1:0]    sync1_r;
  logic [1:0]    sync2_r;
  logic [1:0]    deb_r;
  logic [CW-1:0] cnt_r [2];

  state_t        state_r;
  state_t        state_n;
  state_t        target_s;
  logic [HW-1:0] hold_r;
  logic [HW-1:0] hold_n;
  logic          changed_n;
  logic          as_n;
  logic          gt_n;
  logic          as_r;
  logic          gt_r;
  logic          changed_r;
  logic          legal_s;

  // Two-flop synchroniser for both raw lines.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {RAW_G, RAW_A};
      sync2_r <= sync1_r;
    end
  end

  // Per-line debounce: any cycle of agreement restarts the count.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb_r <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i] <= CNT_ZERO;
        end else if (cnt_r[i] == CNT_LAST) begin
          deb_r[i] <= sync2_r[i];
          cnt_r[i] <= CNT_ZERO;
        end else begin
          cnt_r[i] <= cnt_r[i] + CNT_ONE;
        end
      end
    end
  end

  // Target symbol from the debounced lines; A wins when both are set.
  always_comb begin
    target_s = SHOW_0;
    if (deb_r[0]) begin
      target_s = SHOW_A;
    end else if (deb_r[1]) begin
      target_s = SHOW_G;
    end else begin
      target_s = SHOW_0;
    end
  end

  // Next state, hold counter and output decode.
  always_comb begin
    state_n   = state_r;
    hold_n    = hold_r;
    changed_n = 1'b0;
    as_n      = 1'b0;
    gt_n      = 1'b0;
    legal_s   = 1'b1;

    case (state_r)
      SHOW_0, SHOW_A, SHOW_G: legal_s = 1'b1;
      default:                legal_s = 1'b0;
    endcase

    if (!legal_s) begin
      // Corrupted state register: blank the display and allow an
      // immediate re-selection on the next frame.
      state_n = SHOW_0;
      hold_n  = HOLD_MAX;
    end else if (FRAME_SYNC) begin
      if ((hold_r >= HOLD_MAX) && (target_s != state_r)) begin
        state_n   = target_s;
        hold_n    = HOLD_ONE;
        changed_n = 1'b1;
      end else if (hold_r < HOLD_MAX) begin
        hold_n = hold_r + HOLD_ONE;
      end else begin
        hold_n = hold_r;
      end
    end else begin
      hold_n = hold_r;
    end

    // Selects are decoded from the next state so the registered copies
    // always match the state register one-to-one.
    case (state_n)
      SHOW_A: begin
        as_n = 1'b1;
        gt_n = 1'b0;
      end
      SHOW_G: begin
        as_n = 1'b0;
        gt_n = 1'b1;
      end
      SHOW_0: begin
        as_n = 1'b0;
        gt_n = 1'b0;
      end
      default: begin
        as_n = 1'b0;
        gt_n = 1'b0;
      end
    endcase
  end

  // State, hold counter and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= SHOW_0;
      hold_r    <= HOLD_MAX;
      as_r      <= 1'b0;
      gt_r      <= 1'b0;
      changed_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      hold_r    <= hold_n;
      as_r      <= as_n;
      gt_r      <= gt_n;
      changed_r <= changed_n;
    end
  end

  assign AS      = as_r;
  assign GT      = gt_r;
  assign CHANGED = changed_r;

endmodule

// File: tb/tb_status_symbol_selector.sv
// Directed bench for status_symbol_selector (DEB_CYCLES=16, MIN_HOLD=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so each step() is one clock edge. Expected {AS,GT,CHANGED}
// values are queued as stimulus is applied and popped when the output is read.
module tb_status_symbol_selector;

  logic CLK;
  logic RST;
  logic RAW_A;
  logic RAW_G;
  logic FRAME_SYNC;
  logic AS;
  logic GT;
  logic CHANGED;

  int checks;
  int errors;
  int changed_cnt;
  int illegal_cnt;

  typedef struct {
    string      tag;
    logic [2:0] val;
  } exp_t;

  exp_t sb[$];

  status_symbol_selector #(
    .DEB_CYCLES(16),
    .MIN_HOLD  (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RAW_A     (RAW_A),
    .RAW_G     (RAW_G),
    .FRAME_SYNC(FRAME_SYNC),
    .AS        (AS),
    .GT        (GT),
    .CHANGED   (CHANGED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count CHANGED pulses and illegal AS&GT combinations while out of reset.
  always @(negedge CLK) begin
    if (!RST) begin
      if (CHANGED) changed_cnt = changed_cnt + 1;
      if (AS && GT) illegal_cnt = illegal_cnt + 1;
    end
  end

  task automatic step(input logic fs);
    FRAME_SYNC = fs;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [2:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: observed empty queue, expected an entry");
    end else begin
      e = sb.pop_front();
      assert ({AS, GT, CHANGED} === e.val) else begin
        errors++;
        $error("FAIL %s: observed AS/GT/CHANGED=%b expected %b", e.tag, {AS, GT, CHANGED}, e.val);
      end
    end
  endtask

  task automatic step_chk(input logic fs, input string tag, input logic [2:0] v);
    push_exp(tag, v);
    step(fs);
    pop_check();
  endtask

  task automatic now_chk(input string tag, input logic [2:0] v);
    push_exp(tag, v);
    pop_check();
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    changed_cnt = 0;
    illegal_cnt = 0;
    RST         = 1'b1;
    RAW_A       = 1'b0;
    RAW_G       = 1'b0;
    FRAME_SYNC  = 1'b0;
    #1;
    now_chk("reset_state", 3'b000);
    step_chk(1'b1, "reset_fs_ignored", 3'b000);
    step(1'b0);
    RST = 1'b0;

    // Idle: no requests, frames every 5 cycles, nothing may change.
    for (int f = 0; f < 4; f++) begin
      step_chk(1'b1, "idle_frame", 3'b000);
      repeat (4) step(1'b0);
    end
    chk_int("idle_no_changed", changed_cnt, 0);

    // Both lines high: A has priority. Debounced flip lands on edge 18;
    // FRAME_SYNC on that same edge must not act, the next one (edge 19) does.
    RAW_A = 1'b1;
    RAW_G = 1'b1;
    repeat (17) step(1'b0);
    step_chk(1'b1, "flip_same_edge_no_change", 3'b000);
    step_chk(1'b1, "a_shown_edge19", 3'b101);
    step_chk(1'b0, "changed_one_cycle", 3'b100);

    // Drop A with G still high: G only after A has held for 4 frames.
    RAW_A = 1'b0;
    repeat (18) step(1'b0);
    for (int f = 1; f <= 3; f++) begin
      step_chk(1'b1, "a_min_hold", 3'b100);
      repeat (4) step(1'b0);
    end
    step_chk(1'b1, "g_after_hold", 3'b011);
    step_chk(1'b0, "g_stable", 3'b010);

    // Request "0" while G is shown: G must stay for 4 frames.
    RAW_G = 1'b0;
    repeat (18) step(1'b0);
    for (int f = 1; f <= 3; f++) begin
      step_chk(1'b1, "g_min_hold", 3'b010);
      repeat (4) step(1'b0);
    end
    step_chk(1'b1, "zero_after_hold", 3'b001);
    step_chk(1'b0, "zero_stable", 3'b000);

    // Target goes to A and back to 0 before a permitted frame: no change.
    RAW_A = 1'b1;
    repeat (18) step(1'b0);
    step_chk(1'b1, "revert_hold_blocks", 3'b000);
    repeat (4) step(1'b0);
    RAW_A = 1'b0;
    repeat (18) step(1'b0);
    for (int f = 0; f < 5; f++) begin
      step_chk(1'b1, "revert_no_change", 3'b000);
      repeat (4) step(1'b0);
    end
    chk_int("changed_count_after_hold", changed_cnt, 3);

    // Bounce: G toggles every 10 cycles, never stable long enough.
    for (int c = 0; c < 200; c++) begin
      RAW_G = (((c / 10) % 2) == 0) ? 1'b1 : 1'b0;
      if ((c % 5) == 0) begin
        step_chk(1'b1, "bounce_rejected", 3'b000);
      end else begin
        step(1'b0);
      end
    end
    RAW_G = 1'b0;
    repeat (30) step(1'b0);
    chk_int("bounce_no_changed", changed_cnt, 3);

    // Reset mid-debounce restarts the count: flip 18 edges after release.
    RAW_A = 1'b1;
    repeat (10) step(1'b0);
    RST = 1'b1;
    #1;
    now_chk("rst_mid_debounce", 3'b000);
    repeat (2) step(1'b0);
    RST = 1'b0;
    repeat (17) step(1'b0);
    step_chk(1'b1, "rst_deb_not_early", 3'b000);
    step_chk(1'b1, "rst_deb_flip18", 3'b101);
    step_chk(1'b0, "rst_a_held", 3'b100);

    // Asynchronous reset between edges clears the outputs at once.
    #2;
    RST = 1'b1;
    #1;
    now_chk("rst_async_clear", 3'b000);
    RAW_A = 1'b0;
    step_chk(1'b1, "rst_held", 3'b000);
    RST = 1'b0;
    step_chk(1'b1, "post_rst_idle", 3'b000);

    chk_int("changed_total", changed_cnt, 4);
    chk_int("never_both_high", illegal_cnt, 0);
    chk_int("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
